// File: rtl/jtag_stream_tx_pkg.sv
// Shared address map, status bit layout and read-path select encoding for the
// JTAG streaming mailbox.
package jtag_stream_tx_pkg;

    localparam logic [15:0] STREAM_STATUS_ADDR = 16'h0000;
    localparam logic [15:0] STREAM_PEEK_BASE   = 16'h8000;
    localparam logic [15:0] STREAM_POP_ADDR    = 16'h0001;
    localparam logic [15:0] STREAM_CTRL_ADDR   = 16'h0002;

    localparam int STAT_OVERFLOW_BIT = 31;
    localparam int STAT_FULL_BIT     = 30;
    localparam int STAT_EMPTY_BIT    = 29;

    localparam int CTRL_CLEAR_BIT = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_STATUS,
        SEL_PEEK
    } rd_sel_t;

    function automatic logic [31:0] pack_status(input logic ovf, input logic full,
                                                input logic empty, input logic [15:0] lvl);
        logic [31:0] w;
        w = '0;
        w[STAT_OVERFLOW_BIT] = ovf;
        w[STAT_FULL_BIT]     = full;
        w[STAT_EMPTY_BIT]    = empty;
        w[15:0]              = lvl;
        return w;
    endfunction

endpackage

// File: rtl/jtag_stream_tx_ram.sv
// Simple dual-port word store: one write port, one registered read port.
// No reset so the array maps onto block RAM.
module stream_fifo_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/jtag_stream_tx.sv
// FPGA-to-host streaming mailbox: producer pushes words, JTAG host polls STATUS,
// peeks queued words and pops them through the retimed write strobe.
module jtag_stream_tx
    import jtag_stream_tx_pkg::*;
#(
    parameter int DR_LENGTH  = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int WE_LEN     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_valid,
    input  logic [31:0]          push_data,
    output logic                 push_ready,
    input  logic [DR_LENGTH-1:0] raddr_in,
    input  logic [DR_LENGTH-1:0] waddr_in,
    input  logic [DR_LENGTH-1:0] wdata_in,
    input  logic                 wram_enable,
    output logic [DR_LENGTH-1:0] rdata_out,
    output logic [15:0]          level,
    output logic                 overflow
);

    localparam int PTR_W = DEPTH_LOG2 + 1;

    function automatic logic [15:0] clamp_pop(input logic [DR_LENGTH-1:0] req,
                                              input logic [15:0] lvl);
        if (req > DR_LENGTH'(lvl)) return lvl;
        return req[15:0];
    endfunction

    logic [DR_LENGTH-1:0] raddr_q, waddr_q, wdata_q;
    logic [WE_LEN-1:0]    sr;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, ptr_diff;
    logic                 full, empty, strobe;
    logic                 push_fire, drop, pop_hit, ctrl_hit, clr, flush;
    logic [15:0]          pop_n;
    rd_sel_t              sel_p0, sel_p1;
    logic [31:0]          status_p1, ram_q;
    logic [DEPTH_LOG2-1:0] ram_raddr;
    logic                 unused;

    assign unused = ^{raddr_q[DR_LENGTH-1:16], waddr_q[DR_LENGTH-1:16]};

    // Stage 0: host buses are asynchronous to clk; capture them every cycle.
    always_ff @(posedge clk) begin
        raddr_q <= raddr_in;
        waddr_q <= waddr_in;
        wdata_q <= wdata_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= {sr[WE_LEN-2:0], wram_enable};
    end

    assign strobe = sr[WE_LEN-2] & ~sr[WE_LEN-1];

    assign ptr_diff   = wr_ptr - rd_ptr;
    assign level      = 16'(ptr_diff);
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    assign push_ready = ~full;

    assign push_fire = push_valid & push_ready;
    assign drop      = push_valid & ~push_ready;
    assign pop_hit   = strobe && (waddr_q[15:0] == STREAM_POP_ADDR);
    assign ctrl_hit  = strobe && (waddr_q[15:0] == STREAM_CTRL_ADDR);
    assign clr       = ctrl_hit & wdata_q[CTRL_CLEAR_BIT];
    assign flush     = ctrl_hit & wdata_q[CTRL_FLUSH_BIT];
    assign pop_n     = clamp_pop(wdata_q, level);

    // Flush snaps rd_ptr to the pre-push wr_ptr, so a same-cycle push survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush)        rd_ptr <= wr_ptr;
            else if (pop_hit) rd_ptr <= rd_ptr + pop_n[PTR_W-1:0];
            if (push_fire)    wr_ptr <= wr_ptr + PTR_W'(1);
            if (clr)          overflow <= 1'b0;
            else if (drop)    overflow <= 1'b1;
        end
    end

    // k < level already implies k < depth, so no separate window check is needed.
    always_comb begin
        sel_p0 = SEL_ZERO;
        if (raddr_q[15:0] == STREAM_STATUS_ADDR)
            sel_p0 = SEL_STATUS;
        else if (raddr_q[15] && ({1'b0, raddr_q[14:0]} < level))
            sel_p0 = SEL_PEEK;
    end

    assign ram_raddr = rd_ptr[DEPTH_LOG2-1:0] + raddr_q[DEPTH_LOG2-1:0];

    stream_fifo_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (32)
    ) u_ram (
        .clk   (clk),
        .we    (push_fire),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (push_data),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // Stage 1: decode and status snapshot travel alongside the RAM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_p1 <= SEL_ZERO;
        else     sel_p1 <= sel_p0;
    end

    always_ff @(posedge clk) begin
        status_p1 <= pack_status(overflow, full, empty, level);
    end

    // Stage 2: output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_out <= '0;
        end else begin
            case (sel_p1)
                SEL_STATUS: rdata_out <= DR_LENGTH'(status_p1);
                SEL_PEEK:   rdata_out <= DR_LENGTH'(ram_q);
                default:    rdata_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_stream_tx.sv
// Bench for jtag_stream_tx: directed vector table, strobe-aligned corner cases,
// randomized traffic against a queue model, and a mid-operation reset.
module tb_jtag_stream_tx;

    localparam int DEPTH  = 256;
    localparam int WE_LEN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic [31:0] push_data;
    logic        push_ready;
    logic [31:0] raddr_in, waddr_in, wdata_in;
    logic        wram_enable;
    logic [31:0] rdata_out;
    logic [15:0] level;
    logic        overflow;

    jtag_stream_tx #(
        .DR_LENGTH  (32),
        .DEPTH_LOG2 (8),
        .WE_LEN     (WE_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .push_ready  (push_ready),
        .raddr_in    (raddr_in),
        .waddr_in    (waddr_in),
        .wdata_in    (wdata_in),
        .wram_enable (wram_enable),
        .rdata_out   (rdata_out),
        .level       (level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mq[$];
    logic        m_ovf = 1'b0;

    typedef struct {
        int          op;     // 0 read, 1 push, 2 host write
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int s;
        s = mq.size();
        return {m_ovf, (s == DEPTH), (s == 0), 13'b0, 16'(s)};
    endfunction

    function automatic logic [31:0] m_peek(input int k);
        if (k < mq.size()) return mq[k];
        return 32'h0;
    endfunction

    task automatic model_pop(input logic [31:0] n);
        int cnt;
        cnt = (n > 32'(mq.size())) ? mq.size() : int'(n);
        repeat (cnt) void'(mq.pop_front());
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
        if (addr[15:0] == 16'h0001) model_pop(data);
        if (addr[15:0] == 16'h0002) begin
            if (data[0]) m_ovf = 1'b0;
            if (data[1]) mq.delete();
        end
    endtask

    task automatic push_burst(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            push_data  = base + 32'(i);
            push_valid = 1'b1;
            if (mq.size() < DEPTH) mq.push_back(push_data);
            else m_ovf = 1'b1;
        end
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    task automatic host_write(input logic [31:0] addr, input logic [31:0] data, input int hold);
        @(negedge clk);
        waddr_in    = addr;
        wdata_in    = data;
        wram_enable = 1'b1;
        repeat (hold) @(negedge clk);
        wram_enable = 1'b0;
        repeat (WE_LEN + 2) @(negedge clk);
        model_write(addr, data);
    endtask

    // Push lands on exactly the edge where the write strobe takes effect.
    task automatic write_with_push(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [31:0] word);
        bit full_pre;
        @(negedge clk);
        waddr_in    = addr;
        wdata_in    = data;
        wram_enable = 1'b1;
        repeat (WE_LEN - 1) @(negedge clk);
        push_valid = 1'b1;
        push_data  = word;
        @(negedge clk);
        push_valid  = 1'b0;
        wram_enable = 1'b0;
        repeat (WE_LEN + 2) @(negedge clk);
        full_pre = (mq.size() == DEPTH);
        model_write(addr, data);
        if (full_pre) begin
            if (!(addr[15:0] == 16'h0002 && data[0])) m_ovf = 1'b1;
        end else begin
            mq.push_back(word);
        end
    endtask

    task automatic host_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        raddr_in = addr;
        repeat (3) @(posedge clk);
        #1 data = rdata_out;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".level"}, 32'(level), 32'(mq.size()));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".push_ready"}, 32'(push_ready), 32'(mq.size() < DEPTH));
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        host_read(addr, d);
        check(name, d, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          k, r;

        rst = 1'b1; push_valid = 1'b0; push_data = '0;
        raddr_in = '0; waddr_in = '0; wdata_in = '0; wram_enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.rdata", rdata_out, 32'h0);
        check("reset.level", 32'(level), 32'h0);
        check("reset.overflow", 32'(overflow), 32'h0);
        check("reset.push_ready", 32'(push_ready), 32'h1);
        rst = 1'b0;

        tbl[0]  = '{0, 32'h0000, 32'h0, 32'h2000_0000};
        tbl[1]  = '{1, 32'h0,    32'h1111_1111, 32'h0};
        tbl[2]  = '{1, 32'h0,    32'h2222_2222, 32'h0};
        tbl[3]  = '{1, 32'h0,    32'h3333_3333, 32'h0};
        tbl[4]  = '{0, 32'h0000, 32'h0, 32'h0000_0003};
        tbl[5]  = '{0, 32'h8001, 32'h0, 32'h2222_2222};
        tbl[6]  = '{0, 32'h8003, 32'h0, 32'h0000_0000};
        tbl[7]  = '{2, 32'h0001, 32'h2, 32'h0};
        tbl[8]  = '{0, 32'h0000, 32'h0, 32'h0000_0001};
        tbl[9]  = '{0, 32'h8000, 32'h0, 32'h3333_3333};
        tbl[10] = '{2, 32'h0001, 32'h5, 32'h0};
        tbl[11] = '{0, 32'h0000, 32'h0, 32'h2000_0000};
        tbl[12] = '{0, 32'h1234, 32'h0, 32'h0000_0000};
        tbl[13] = '{0, 32'h8000, 32'h0, 32'h0000_0000};

        for (int i = 0; i < 14; i++) begin
            case (tbl[i].op)
                0: read_check($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp);
                1: push_burst(1, tbl[i].data);
                default: host_write(tbl[i].addr, tbl[i].data, 1);
            endcase
        end
        check_state("vec_end");

        push_burst(255, 32'hA000_0000);
        check("fill255.push_ready", 32'(push_ready), 32'h1);
        push_burst(1, 32'hA000_00FF);
        check("fill256.push_ready", 32'(push_ready), 32'h0);
        check("fill256.overflow", 32'(overflow), 32'h0);
        push_burst(1, 32'hEEEE_EEEE);
        check("drop.overflow", 32'(overflow), 32'h1);
        read_check("full.status", 32'h0000, 32'hC000_0100);
        read_check("full.peek255", 32'h80FF, 32'hA000_00FF);
        host_write(32'h0002, 32'h1, 1);
        read_check("clear.status", 32'h0000, 32'h4000_0100);

        write_with_push(32'h0002, 32'h1, 32'hDEAD_BEEF);
        read_check("drop_vs_clear.status", 32'h0000, 32'h4000_0100);
        check_state("drop_vs_clear");

        host_write(32'h0001, 32'd300, 1);
        read_check("drain.status", 32'h0000, 32'h2000_0000);

        push_burst(4, 32'hB000_0000);
        host_write(32'h0001, 32'h1, 20);
        read_check("held_we.status", 32'h0000, 32'h0000_0003);
        read_check("held_we.peek0", 32'h8000, 32'hB000_0001);

        push_burst(1, 32'hB000_0004);
        write_with_push(32'h0001, 32'h2, 32'hC000_0000);
        read_check("push_pop.status", 32'h0000, 32'h0000_0003);
        read_check("push_pop.head", 32'h8000, 32'hB000_0003);
        read_check("push_pop.tail", 32'h8002, 32'hC000_0000);

        write_with_push(32'h0002, 32'h2, 32'hD000_0000);
        read_check("flush_push.status", 32'h0000, 32'h0000_0001);
        read_check("flush_push.peek0", 32'h8000, 32'hD000_0000);
        check_state("directed_end");

        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: push_burst($urandom_range(1, 40), $urandom);
                3, 4:    host_write(32'h0001, $urandom_range(0, mq.size() + 3), 1);
                5: read_check("rnd.status", 32'h0000, m_status());
                6, 7: begin
                    k = $urandom_range(0, 300);
                    host_read(32'h8000 + 32'(k), d);
                    check($sformatf("rnd.peek%0d", k), d, m_peek(k));
                end
                8: host_write(32'h0002, 32'($urandom_range(0, 1)) |
                              (($urandom_range(0, 5) == 0) ? 32'h2 : 32'h0), 1);
                default: read_check("rnd.other", 32'h4000 | 32'($urandom_range(0, 16'h3FFF)), 32'h0);
            endcase
            check_state("rnd");
        end

        push_burst(3, 32'hF000_0000);
        @(negedge clk);
        waddr_in = 32'h0001; wdata_in = 32'h1; wram_enable = 1'b1;
        @(negedge clk);
        wram_enable = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst.level", 32'(level), 32'h0);
        check("midrst.overflow", 32'(overflow), 32'h0);
        check("midrst.rdata", rdata_out, 32'h0);
        #1 rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_data  = 32'hF100_0000 + 32'(i);
            push_valid = 1'b1;
            mq.push_back(push_data);
            @(negedge clk);
        end
        push_valid = 1'b0;
        repeat (6) @(negedge clk);
        check_state("midrst_after");
        read_check("midrst.peek0", 32'h8000, 32'hF100_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_stream_tx.md
# jtag_stream_tx

FPGA-to-host streaming mailbox on the virtual JTAG DR interface. On-chip logic pushes 32-bit words into an internal FIFO; the JTAG host polls a status word, peeks queued words through the read window, then acknowledges (pops) them through the write strobe. It sits between `jtag_top` (address/data/enable outputs, `rdata_in` input) and any producer in the `clk` domain, alongside the block-RAM responder.

## Interface
- `DR_LENGTH`, 32: JTAG data register width; all host-side buses.
- `DEPTH_LOG2`, 8: FIFO depth is 2^DEPTH_LOG2 words. Legal range 2..15.
- `WE_LEN`, 4: length of the write-enable retiming shift register; minimum 2.

- `clk` in 1: system clock (PLL output).
- `rst` in 1: reset, asynchronous, active-high.
- `push_valid` in 1: producer has a word.
- `push_data` in 32: producer word.
- `push_ready` out 1: FIFO not full.
- `raddr_in` in DR_LENGTH: host read address, from `jtag_top` `raddr_out`, asynchronous to `clk`.
- `waddr_in` in DR_LENGTH: host write address, from `waddr_out`.
- `wdata_in` in DR_LENGTH: host write data, from `wdata_out`.
- `wram_enable` in 1: host write enable, from `jtag_top`, asynchronous level.
- `rdata_out` out DR_LENGTH: to `jtag_top` `rdata_in`.
- `level` out 16: words currently queued.
- `overflow` out 1: sticky, set when a push was dropped.

## Operation
- Host inputs are registered into `clk` every cycle (`raddr_q`, `waddr_q`, `wdata_q`). `wram_enable` shifts through a WE_LEN-bit register; the write strobe is `sr[WE_LEN-2] & !sr[WE_LEN-1]`, one `clk` cycle per host write.
- Read map (on `raddr_q[15:0]`):
  - 0x0000 STATUS: [31] overflow, [30] full, [29] empty, [28:16] zero, [15:0] level.
  - 0x8000+k: peek word at `rd_ptr+k`, k < 2^DEPTH_LOG2. If k ≥ level, returns 0.
  - Any other address returns 0x00000000.
- Write map (on strobe, `waddr_q[15:0]`):
  - 0x0001 POP: discard min(`wdata_q`, level) words from the head.
  - 0x0002 CTRL: `wdata_q[0]`=1 clears `overflow`; `wdata_q[1]`=1 flushes (rd_ptr ← wr_ptr).
  - Others ignored.
- Push: accepted when `push_valid & push_ready`. `push_valid & !push_ready` drops the word and sets `overflow`. The drop has no other effect.
- Pointers are DEPTH_LOG2+1 bits and wrap naturally. `full` = MSBs differ and the rest equal. `level` = wr_ptr − rd_ptr, zero-extended to 16 bits.
- Same-cycle push and POP: both apply. New level = level + 1 − popped count. The clamp uses the pre-push level.
- Same-cycle drop and CTRL clear: clear wins; `overflow` ends at 0.
- Flush and push in the same cycle: flush applies first, then the push lands, so level = 1.

## Timing
- Reset values: `rdata_out`=0, `level`=0, `overflow`=0, `push_ready`=1, pointers 0, shift register 0.
- Peek/STATUS latency: a `raddr_in` change appears on `rdata_out` 3 `clk` cycles later (register, sync RAM read, output register). STATUS tracks live state with the same latency.
- Write latency: the strobe fires WE_LEN−1 cycles after `wram_enable` rises. Pointer and flags update on the next edge. One strobe per rising edge of `wram_enable`; a held level does not repeat the action.
- `push_ready` is combinational from pointers, valid the cycle after any pointer update.
- Reset mid-operation: a pending strobe in the shift register is discarded and FIFO contents are lost. The host must re-read STATUS.

## Structure
- Address constants `STREAM_STATUS_ADDR`, `STREAM_PEEK_BASE`, `STREAM_POP_ADDR`, `STREAM_CTRL_ADDR` and status bit positions go in `defines.v`, next to `DR_LENGTH`.
- One sub-module, `stream_fifo_ram`: simple dual-port, one write port and one synchronous read port, 2^DEPTH_LOG2 × 32, inferred M9K. All pointer and flag logic stays in `jtag_stream_tx`.

## Test plan
- Reset, then read 0x0000 → 0x20000000 (empty). `push_ready`=1.
- Push 0x11111111, 0x22222222, 0x33333333. Read 0x0000 → 0x00000003. Read 0x8001 → 0x22222222. Read 0x8003 → 0x00000000.
- POP with wdata=2 → level 1. Read 0x8000 → 0x33333333. POP with wdata=5 → level 0, no underflow.
- Push 257 words with DEPTH_LOG2=8 → `push_ready` low after 256. The 257th push sets `overflow`. STATUS → 0xC0000100. CTRL wdata=1 → `overflow`=0.
- Hold `wram_enable` high 20 cycles with POP wdata=1 and level=4 → exactly one pop, level 3.
- Push on the same cycle as the POP strobe (level 4, pop 2) → level 3, and the pushed word is at the tail.
